// File: rtl/pattern_seq_pkg.sv
// Shared types and LFSR helpers for the multi-channel pattern sequencer.
package pattern_seq_pkg;

    // Pattern generation modes, encoded as written through cfg_mode
    typedef enum logic [1:0] {
        CONST = 2'd0,
        TABLE = 2'd1,
        COUNT = 2'd2,
        LFSR  = 2'd3
    } mode_e;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } chan_state_e;

    localparam int LFSR_MAX_W = 16;

    // Maximal-length feedback masks for a right-shifting Galois LFSR
    function automatic logic [LFSR_MAX_W-1:0] lfsr_taps(input int width);
        logic [LFSR_MAX_W-1:0] taps;
        case (width)
            2:       taps = 16'h0003;
            3:       taps = 16'h0006;
            4:       taps = 16'h000C;
            5:       taps = 16'h0014;
            6:       taps = 16'h0030;
            7:       taps = 16'h0060;
            8:       taps = 16'h00B8;
            9:       taps = 16'h0110;
            10:      taps = 16'h0240;
            11:      taps = 16'h0500;
            12:      taps = 16'h0829;
            13:      taps = 16'h100D;
            14:      taps = 16'h2015;
            15:      taps = 16'h6000;
            16:      taps = 16'hD008;
            default: taps = 16'h0003;
        endcase
        return taps;
    endfunction

    // One Galois step: shift right, fold the taps in when a one falls out
    function automatic logic [LFSR_MAX_W-1:0] lfsr_next(input logic [LFSR_MAX_W-1:0] value,
                                                        input int width);
        logic [LFSR_MAX_W-1:0] mask;
        logic [LFSR_MAX_W-1:0] v;
        mask = (16'h0001 << width) - 16'h0001;
        v    = value & mask;
        if (v[0]) begin
            return ((v >> 1) ^ lfsr_taps(width)) & mask;
        end
        return v >> 1;
    endfunction

endpackage

// File: rtl/pattern_seq_chan.sv
// One sequencer channel: pattern table, config registers, run FSM,
// pattern generator and beat down-counter behind a valid/ready handshake.
//
// state | meaning
// IDLE  | output parked at RESET_VAL, valid low, config writes accepted
// RUN   | presenting beats, config writes ignored
module pattern_seq_chan
    import pattern_seq_pkg::*;
#(
    parameter int               WIDTH     = 3,
    parameter int               DEPTH     = 4,
    parameter int               CNT_W     = 16,
    parameter int               IDX_W     = 2,
    parameter logic [WIDTH-1:0] RESET_VAL = 3'b101
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [1:0]       wr_mode,
    input  logic [IDX_W:0]   wr_len,
    input  logic [CNT_W-1:0] wr_count,
    input  logic             launch,
    input  logic             abort,
    input  logic             ready,
    output logic             valid,
    output logic [WIDTH-1:0] data,
    output logic             running,
    output logic             finish
);

    chan_state_e      state_q;
    logic [WIDTH-1:0] tbl_q [DEPTH];
    mode_e            mode_q;
    logic [IDX_W:0]   len_q;
    logic [CNT_W-1:0] count_q;

    logic [IDX_W-1:0] idx_q;
    logic [CNT_W-1:0] beats_q;
    logic             endless_q;
    logic [WIDTH-1:0] data_q;
    logic             valid_q;

    logic             accept;
    logic             last_beat;
    logic [WIDTH-1:0] first_val;
    logic [IDX_W:0]   idx_inc;
    logic [IDX_W-1:0] idx_nxt;
    logic [WIDTH-1:0] data_nxt;

    assign accept    = valid_q & ready;
    assign last_beat = !endless_q && (beats_q == CNT_W'(1));
    assign finish    = (state_q == RUN) && accept && last_beat && !abort;
    assign valid     = valid_q;
    assign data      = data_q;
    assign running   = (state_q == RUN);

    // An all-zero LFSR would lock up, so a zero seed is promoted to 1
    assign first_val = ((mode_q == LFSR) && (tbl_q[0] == '0)) ? WIDTH'(1) : tbl_q[0];

    // Table walk wraps at len; a stray len of 0 just pins the index at 0
    assign idx_inc = {1'b0, idx_q} + (IDX_W+1)'(1);
    assign idx_nxt = (idx_inc >= len_q) ? '0 : idx_inc[IDX_W-1:0];

    // Value presented after the current beat is accepted
    always_comb begin
        data_nxt = data_q;
        case (mode_q)
            CONST:   data_nxt = tbl_q[0];
            TABLE:   data_nxt = tbl_q[idx_nxt];
            COUNT:   data_nxt = data_q + WIDTH'(1);
            LFSR:    data_nxt = WIDTH'(lfsr_next(LFSR_MAX_W'(data_q), WIDTH));
            default: data_nxt = tbl_q[0];
        endcase
    end

    // Config capture; mode, len and count ride along with every table write
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                tbl_q[i] <= '0;
            end
            mode_q  <= CONST;
            len_q   <= (IDX_W+1)'(1);
            count_q <= '0;
        end else if (wr_en && (state_q == IDLE)) begin
            tbl_q[wr_idx] <= wr_data;
            mode_q        <= mode_e'(wr_mode);
            len_q         <= wr_len;
            count_q       <= wr_count;
        end
    end

    // Run FSM with registered pattern, valid and beat counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            data_q    <= RESET_VAL;
            valid_q   <= 1'b0;
            idx_q     <= '0;
            beats_q   <= '0;
            endless_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (launch) begin
                        state_q   <= RUN;
                        valid_q   <= 1'b1;
                        data_q    <= first_val;
                        idx_q     <= '0;
                        beats_q   <= count_q;
                        endless_q <= (count_q == '0);
                    end
                end
                RUN: begin
                    if (abort || (accept && last_beat)) begin
                        state_q <= IDLE;
                        valid_q <= 1'b0;
                        data_q  <= RESET_VAL;
                    end else if (accept) begin
                        data_q <= data_nxt;
                        idx_q  <= idx_nxt;
                        if (!endless_q) begin
                            beats_q <= beats_q - CNT_W'(1);
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    valid_q <= 1'b0;
                    data_q  <= RESET_VAL;
                end
            endcase
        end
    end

endmodule

// File: rtl/pattern_seq_top.sv
// Multi-channel pattern sequencer: config decode, start/stop fan-out,
// busy reduction and all-channels-finished done pulse.
module pattern_seq_top
    import pattern_seq_pkg::*;
#(
    parameter int               WIDTH     = 3,
    parameter int               NUM_CH    = 2,
    parameter int               DEPTH     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = 3'b101,
    parameter int               CNT_W     = 16,
    localparam int              CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int              IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cfg_we,
    input  logic [CH_W-1:0]         cfg_ch,
    input  logic [IDX_W-1:0]        cfg_idx,
    input  logic [WIDTH-1:0]        cfg_data,
    input  logic [1:0]              cfg_mode,
    input  logic [IDX_W:0]          cfg_len,
    input  logic [CNT_W-1:0]        cfg_count,
    input  logic [NUM_CH-1:0]       ch_en,
    input  logic                    start,
    input  logic                    stop,
    output logic [NUM_CH-1:0]       sig_valid,
    input  logic [NUM_CH-1:0]       sig_ready,
    output logic [NUM_CH*WIDTH-1:0] sig_a,
    output logic                    busy,
    output logic                    done
);

    logic [NUM_CH-1:0] running;
    logic [NUM_CH-1:0] finish;
    logic [NUM_CH-1:0] launch;
    logic [NUM_CH-1:0] pending_q;
    logic [NUM_CH-1:0] pending_left;
    logic              start_go;
    logic              done_q;

    // A start is honoured only when every channel is idle and stop is absent
    assign start_go     = start && !stop && !(|running);
    assign launch       = start_go ? ch_en : '0;
    assign pending_left = pending_q & ~finish;
    assign busy         = |running;
    assign done         = done_q;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_chan
        logic wr_sel;
        assign wr_sel = cfg_we && (cfg_ch == CH_W'(c));

        pattern_seq_chan #(
            .WIDTH    (WIDTH),
            .DEPTH    (DEPTH),
            .CNT_W    (CNT_W),
            .IDX_W    (IDX_W),
            .RESET_VAL(RESET_VAL)
        ) u_chan (
            .clk     (clk),
            .rst     (rst),
            .wr_en   (wr_sel),
            .wr_idx  (cfg_idx),
            .wr_data (cfg_data),
            .wr_mode (cfg_mode),
            .wr_len  (cfg_len),
            .wr_count(cfg_count),
            .launch  (launch[c]),
            .abort   (stop),
            .ready   (sig_ready[c]),
            .valid   (sig_valid[c]),
            .data    (sig_a[c*WIDTH +: WIDTH]),
            .running (running[c]),
            .finish  (finish[c])
        );
    end

    // Track launched channels; done fires when the last one finishes by count
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_q <= '0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (stop) begin
                pending_q <= '0;
            end else if (start_go) begin
                pending_q <= ch_en;
            end else begin
                pending_q <= pending_left;
                done_q    <= (pending_q != '0) && (pending_left == '0);
            end
        end
    end

endmodule

// File: tb/tb_pattern_seq_top.sv
// Self-checking bench for pattern_seq_top (WIDTH=3, NUM_CH=2, DEPTH=4).
module tb_pattern_seq_top;
    import pattern_seq_pkg::*;

    localparam int               WIDTH  = 3;
    localparam int               NUM_CH = 2;
    localparam int               DEPTH  = 4;
    localparam int               CNT_W  = 16;
    localparam logic [WIDTH-1:0] RST_V  = 3'b101;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    cfg_we;
    logic                    cfg_ch;
    logic [1:0]              cfg_idx;
    logic [WIDTH-1:0]        cfg_data;
    logic [1:0]              cfg_mode;
    logic [2:0]              cfg_len;
    logic [CNT_W-1:0]        cfg_count;
    logic [NUM_CH-1:0]       ch_en;
    logic                    start;
    logic                    stop;
    logic [NUM_CH-1:0]       sig_valid;
    logic [NUM_CH-1:0]       sig_ready;
    logic [NUM_CH*WIDTH-1:0] sig_a;
    logic                    busy;
    logic                    done;

    always #5 clk = ~clk;

    pattern_seq_top #(
        .WIDTH(WIDTH), .NUM_CH(NUM_CH), .DEPTH(DEPTH), .RESET_VAL(RST_V), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_idx(cfg_idx),
        .cfg_data(cfg_data), .cfg_mode(cfg_mode), .cfg_len(cfg_len), .cfg_count(cfg_count),
        .ch_en(ch_en), .start(start), .stop(stop), .sig_valid(sig_valid),
        .sig_ready(sig_ready), .sig_a(sig_a), .busy(busy), .done(done)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference configuration as the bench believes it was written
    int m_tbl  [NUM_CH][DEPTH];
    int m_mode [NUM_CH];
    int m_len  [NUM_CH];
    int m_count[NUM_CH];

    int acc_q[NUM_CH][$];
    int done_cnt, done_at, idle_at;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [WIDTH-1:0] ch_data(input int c);
        return sig_a[c*WIDTH +: WIDTH];
    endfunction

    // x^3 + x^2 + 1, right-shifting Galois form
    function automatic int lfsr3_step(input int v);
        return (v % 2 == 1) ? ((v / 2) ^ 6) : (v / 2);
    endfunction

    // Expected i-th accepted beat of a channel, straight from the mode rules
    function automatic int model_beat(input int c, input int i);
        int v;
        case (m_mode[c])
            0:       return m_tbl[c][0];
            1:       return m_tbl[c][i % m_len[c]];
            2:       return (m_tbl[c][0] + i) % 8;
            default: begin
                v = m_tbl[c][0];
                if (v == 0) v = 1;
                for (int k = 0; k < i; k++) v = lfsr3_step(v);
                return v;
            end
        endcase
    endfunction

    task automatic cfg_write(input int ch, input int idx, input int data, input mode_e mode,
                             input int len, input int count, input bit applies);
        cfg_we    = 1'b1;
        cfg_ch    = 1'(ch);
        cfg_idx   = 2'(idx);
        cfg_data  = 3'(data);
        cfg_mode  = mode;
        cfg_len   = 3'(len);
        cfg_count = 16'(count);
        tick;
        cfg_we = 1'b0;
        if (applies) begin
            m_tbl[ch][idx] = data;
            m_mode[ch]     = int'(mode);
            m_len[ch]      = len;
            m_count[ch]    = count;
        end
    endtask

    // Launch, then apply a ready pattern and record every accepted beat
    task automatic run_collect(input logic [NUM_CH-1:0] en, input int ready_mode, input int max_cyc);
        logic [NUM_CH-1:0] prev_stall;
        logic [WIDTH-1:0]  prev_data[NUM_CH];
        logic [NUM_CH-1:0] rdy;
        for (int c = 0; c < NUM_CH; c++) acc_q[c].delete();
        done_cnt = 0; done_at = -1; idle_at = -1;
        ch_en = en;
        start = 1'b1;
        tick;
        start = 1'b0;
        prev_stall = '0;
        for (int cyc = 0; cyc < max_cyc; cyc++) begin
            case (ready_mode)
                0:       rdy = '1;
                1:       rdy = (cyc % 2 == 0) ? '1 : '0;
                default: for (int c = 0; c < NUM_CH; c++) rdy[c] = ($urandom_range(0, 99) < 70);
            endcase
            sig_ready = rdy;
            for (int c = 0; c < NUM_CH; c++) begin
                if (prev_stall[c]) begin
                    check($sformatf("stall_valid_ch%0d", c), sig_valid[c], 1'b1);
                    check($sformatf("stall_data_ch%0d", c), ch_data(c), prev_data[c]);
                end
                if (sig_valid[c] && rdy[c]) acc_q[c].push_back(int'(ch_data(c)));
                prev_stall[c] = sig_valid[c] && !rdy[c];
                prev_data[c]  = ch_data(c);
            end
            tick;
            if (done) begin
                done_cnt++;
                done_at = cyc;
            end
            if (!busy) begin
                idle_at = cyc;
                break;
            end
        end
        if (idle_at < 0) check("run_timeout_busy", busy, 1'b0);
    endtask

    typedef struct {
        logic             start;
        logic [1:0]       ready;
        logic             valid0;
        logic [WIDTH-1:0] a0;
        logic             busy;
        logic             done;
    } vec_t;

    vec_t vecs[6];
    int   exp3[7]  = '{1, 2, 4, 1, 2, 4, 1};
    int   exp4[10] = '{6, 7, 0, 1, 2, 3, 4, 5, 6, 7};

    initial begin
        logic [7:0] seen;
        logic [NUM_CH-1:0] en;

        rst = 1'b1; cfg_we = 0; cfg_ch = 0; cfg_idx = 0; cfg_data = 0; cfg_mode = 0;
        cfg_len = 1; cfg_count = 0; ch_en = 0; start = 0; stop = 0; sig_ready = '1;
        for (int c = 0; c < NUM_CH; c++) begin
            for (int i = 0; i < DEPTH; i++) m_tbl[c][i] = 0;
            m_mode[c] = 0; m_len[c] = 1; m_count[c] = 0;
        end

        // Reset state
        tick; tick;
        check("reset_sig_a", sig_a, {RST_V, RST_V});
        check("reset_valid", sig_valid, 2'b00);
        check("reset_busy", busy, 1'b0);
        check("reset_done", done, 1'b0);
        rst = 1'b0;
        tick;

        // CONST run of 4 beats, table-driven cycle by cycle
        cfg_write(0, 0, 3, CONST, 1, 4, 1);
        vecs[0] = '{1'b1, 2'b11, 1'b1, 3'b011, 1'b1, 1'b0};
        vecs[1] = '{1'b0, 2'b11, 1'b1, 3'b011, 1'b1, 1'b0};
        vecs[2] = '{1'b0, 2'b11, 1'b1, 3'b011, 1'b1, 1'b0};
        vecs[3] = '{1'b0, 2'b11, 1'b1, 3'b011, 1'b1, 1'b0};
        vecs[4] = '{1'b0, 2'b11, 1'b0, RST_V,  1'b0, 1'b1};
        vecs[5] = '{1'b0, 2'b11, 1'b0, RST_V,  1'b0, 1'b0};
        ch_en = 2'b01;
        for (int i = 0; i < 6; i++) begin
            start     = vecs[i].start;
            sig_ready = vecs[i].ready;
            tick;
            start = 1'b0;
            check($sformatf("vec%0d_valid0", i), sig_valid[0], vecs[i].valid0);
            check($sformatf("vec%0d_a0", i), ch_data(0), vecs[i].a0);
            check($sformatf("vec%0d_valid1", i), sig_valid[1], 1'b0);
            check($sformatf("vec%0d_a1", i), ch_data(1), RST_V);
            check($sformatf("vec%0d_busy", i), busy, vecs[i].busy);
            check($sformatf("vec%0d_done", i), done, vecs[i].done);
        end

        // TABLE run on ch1 with ready toggling
        cfg_write(1, 0, 1, TABLE, 3, 7, 1);
        cfg_write(1, 1, 2, TABLE, 3, 7, 1);
        cfg_write(1, 2, 4, TABLE, 3, 7, 1);
        run_collect(2'b10, 1, 100);
        check("table_len", acc_q[1].size(), 7);
        for (int i = 0; i < 7 && i < acc_q[1].size(); i++)
            check($sformatf("table_beat%0d", i), acc_q[1][i], exp3[i]);
        check("table_done_cnt", done_cnt, 1);
        check("table_done_at_idle", done_at, idle_at);

        // COUNT on ch0 alongside TABLE on ch1; done only after the slower one
        cfg_write(0, 0, 6, COUNT, 1, 10, 1);
        run_collect(2'b11, 0, 100);
        check("count_len", acc_q[0].size(), 10);
        for (int i = 0; i < 10 && i < acc_q[0].size(); i++)
            check($sformatf("count_beat%0d", i), acc_q[0][i], exp4[i]);
        check("count_ch1_len", acc_q[1].size(), 7);
        check("count_done_cnt", done_cnt, 1);
        check("count_done_at_idle", done_at, idle_at);
        check("count_idle_cycle", idle_at, 9);
        tick;
        check("count_done_drop", done, 1'b0);
        check("count_sig_a_idle", sig_a, {RST_V, RST_V});

        // LFSR with zero seed
        cfg_write(0, 0, 0, LFSR, 1, 14, 1);
        run_collect(2'b01, 2, 200);
        check("lfsr_len", acc_q[0].size(), 14);
        if (acc_q[0].size() == 14) begin
            check("lfsr_first", acc_q[0][0], 1);
            seen = '0;
            for (int i = 0; i < 7; i++) seen[acc_q[0][i]] = 1'b1;
            check("lfsr_zero_absent", seen[0], 1'b0);
            check("lfsr_distinct", $countones(seen), 7);
            for (int i = 0; i < 7; i++)
                check($sformatf("lfsr_repeat%0d", i), acc_q[0][i+7], acc_q[0][i]);
            for (int i = 0; i < 14; i++)
                check($sformatf("lfsr_model%0d", i), acc_q[0][i], model_beat(0, i));
        end

        // Endless run, ignored start, dropped write, start+stop collision
        cfg_write(0, 0, 2, CONST, 1, 0, 1);
        ch_en = 2'b01; start = 1'b1; tick; start = 1'b0;
        sig_ready = 2'b11;
        for (int i = 0; i < 20; i++) tick;
        check("endless_valid", sig_valid[0], 1'b1);
        check("endless_data", ch_data(0), 3'd2);
        ch_en = 2'b10; start = 1'b1; tick; start = 1'b0;
        check("busy_start_ch1_valid", sig_valid[1], 1'b0);
        cfg_write(0, 0, 7, CONST, 1, 3, 0);
        ch_en = 2'b11; start = 1'b1; stop = 1'b1; tick; start = 1'b0; stop = 1'b0;
        check("stop_valid", sig_valid, 2'b00);
        check("stop_busy", busy, 1'b0);
        check("stop_done", done, 1'b0);
        check("stop_sig_a", sig_a, {RST_V, RST_V});
        tick;
        check("stop_no_launch", busy, 1'b0);
        check("stop_done_later", done, 1'b0);
        ch_en = 2'b01; start = 1'b1; tick; start = 1'b0;
        check("write_dropped_data", ch_data(0), 3'd2);
        for (int i = 0; i < 6; i++) tick;
        check("write_dropped_count", busy, 1'b1);
        stop = 1'b1; tick; stop = 1'b0;
        check("stop2_valid", sig_valid[0], 1'b0);

        // Randomized configs against the reference model
        for (int it = 0; it < 15; it++) begin
            for (int c = 0; c < NUM_CH; c++) begin
                mode_e md;
                int    ln, cn;
                md = mode_e'($urandom_range(0, 3));
                ln = $urandom_range(1, 4);
                cn = $urandom_range(1, 12);
                for (int i = 0; i < DEPTH; i++) cfg_write(c, i, $urandom_range(0, 7), md, ln, cn, 1);
            end
            en = 2'($urandom_range(1, 3));
            run_collect(en, 2, 400);
            for (int c = 0; c < NUM_CH; c++) begin
                if (en[c]) begin
                    check($sformatf("rnd%0d_ch%0d_len", it, c), acc_q[c].size(), m_count[c]);
                    for (int i = 0; i < acc_q[c].size() && i < m_count[c]; i++)
                        check($sformatf("rnd%0d_ch%0d_beat%0d", it, c, i), acc_q[c][i], model_beat(c, i));
                end else begin
                    check($sformatf("rnd%0d_ch%0d_silent", it, c), acc_q[c].size(), 0);
                end
            end
            check($sformatf("rnd%0d_done_cnt", it), done_cnt, 1);
            check($sformatf("rnd%0d_done_at", it), done_at, idle_at);
        end

        // Reset in the middle of a run clears everything, tables included
        cfg_write(0, 0, 5, TABLE, 2, 0, 1);
        ch_en = 2'b01; start = 1'b1; tick; start = 1'b0;
        tick; tick;
        #2 rst = 1'b1;
        #1;
        check("midrst_sig_a", sig_a, {RST_V, RST_V});
        check("midrst_valid", sig_valid, 2'b00);
        check("midrst_busy", busy, 1'b0);
        tick;
        rst = 1'b0;
        tick;
        ch_en = 2'b01; start = 1'b1; tick; start = 1'b0;
        check("midrst_table_cleared", ch_data(0), 3'd0);
        for (int i = 0; i < 5; i++) tick;
        check("midrst_count_cleared", busy, 1'b1);
        stop = 1'b1; tick; stop = 1'b0;
        check("midrst_stop", busy, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
